wb_write_arbiter: RTL and testbench



---
 rtl/wb_write_arbiter_pkg.sv | 22 ++
 rtl/wb_queue.sv | 108 ++++++++++
 rtl/wb_write_arbiter.sv | 163 ++++++++++++++++
 tb/tb_wb_write_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_write_arbiter_pkg
//  Description : Shared register-file constants for the write-port arbiter
//                (bus widths, enable levels, zero word).
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_write_arbiter_pkg;

    localparam int RegNumLog2 = 5;
    localparam int RegAddrBus = RegNumLog2;
    localparam int RegBus     = 32;

    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic ReadEnable   = 1'b1;
    localparam logic RstEnable    = 1'b1;

    localparam logic [RegBus-1:0] ZeroWord = '0;

endpackage
`default_nettype wire

// File: rtl/wb_queue.sv
`default_nettype none
// ============================================================================
//  Module      : wb_queue
//  Description : In-order circular buffer for long-latency register writes.
//                Each slot has a valid bit that can be cleared by an
//                address-match squash; a squashed head is discarded by the
//                owner through the pop input. Two match ports report whether
//                any valid slot targets a given register.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_queue
    import wb_write_arbiter_pkg::*;
#(
    parameter int DATA_W = RegBus,
    parameter int ADDR_W = RegAddrBus,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_push_vld,
    input  logic [ADDR_W-1:0]        i_push_addr,
    input  logic [DATA_W-1:0]        i_push_data,
    input  logic                     i_pop,
    input  logic                     i_sq_en,
    input  logic [ADDR_W-1:0]        i_sq_addr,
    input  logic [ADDR_W-1:0]        i_match_addr1,
    input  logic [ADDR_W-1:0]        i_match_addr2,
    output logic                     o_head_vld,
    output logic [ADDR_W-1:0]        o_head_addr,
    output logic [DATA_W-1:0]        o_head_data,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_match1,
    output logic                     o_match2
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]  r_vld;
    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    // Slot storage, squash, pop/push pointers and occupancy count.
    // Popping clears the slot's valid bit so free slots never produce matches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            r_vld   <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_sq_en && (r_addr[i] == i_sq_addr)) begin
                    r_vld[i] <= 1'b0;
                end
            end
            if (i_pop) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + 1'b1;
            end
            // Push slot never equals the popped slot: push needs !full, pop needs !empty.
            if (i_push) begin
                r_vld[r_tail]  <= i_push_vld;
                r_addr[r_tail] <= i_push_addr;
                r_data[r_tail] <= i_push_data;
                r_tail         <= r_tail + 1'b1;
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!i_push && i_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_head_vld  = r_vld[r_head];
    assign o_head_addr = r_addr[r_head];
    assign o_head_data = r_data[r_head];
    assign o_empty     = (r_count == '0);
    assign o_full      = (r_count == CNT_W'(DEPTH));
    assign o_count     = r_count;

    // Pending-write lookup across all valid slots for both decode read ports.
    always_comb begin
        o_match1 = 1'b0;
        o_match2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (r_addr[i] == i_match_addr1)) begin
                o_match1 = 1'b1;
            end
            if (r_vld[i] && (r_addr[i] == i_match_addr2)) begin
                o_match2 = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_write_arbiter
//  Description : Register-file write-port arbiter. The pipeline write-back
//                has fixed priority; long-latency results are queued and
//                drain into idle write-port cycles. Exports pending-write
//                hits for decode-stage operand stalls.
//  Options     : WB_STARVE_STALL_EN - enables the head-starvation counter
//                and the registered stall_req output.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_write_arbiter
    import wb_write_arbiter_pkg::*;
#(
    parameter int DATA_W = RegBus,
    parameter int ADDR_W = RegAddrBus,
    parameter int DEPTH  = 4
`ifdef WB_STARVE_STALL_EN
    ,
    parameter int STARVE_LIMIT = 8
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pipe_we,
    input  logic [ADDR_W-1:0]        pipe_waddr,
    input  logic [DATA_W-1:0]        pipe_wdata,
    input  logic                     sec_valid,
    output logic                     sec_ready,
    input  logic [ADDR_W-1:0]        sec_waddr,
    input  logic [DATA_W-1:0]        sec_wdata,
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_waddr,
    output logic [DATA_W-1:0]        rf_wdata,
    input  logic [ADDR_W-1:0]        raddr1,
    input  logic                     re1,
    output logic                     pend_hit1,
    input  logic [ADDR_W-1:0]        raddr2,
    input  logic                     re2,
    output logic                     pend_hit2,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic                     stall_req
);

    logic                    r_run;
    logic                    w_pipe_eff;
    logic                    w_accept;
    logic                    w_push;
    logic                    w_push_vld;
    logic                    w_pop;
    logic                    w_head_vld;
    logic [ADDR_W-1:0]       w_head_addr;
    logic [DATA_W-1:0]       w_head_data;
    logic                    w_empty;
    logic                    w_full;
    logic                    w_match1;
    logic                    w_match2;
    logic [$clog2(DEPTH):0]  w_count;

    // Out-of-reset flag: holds the port quiet and sec_ready low until the
    // first clock edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // A pipeline write to register 0 is treated as an idle port cycle.
    assign w_pipe_eff = r_run & pipe_we & (pipe_waddr != '0);

    // No pass-through when full, even if the head pops this cycle.
    assign sec_ready  = r_run & ~w_full;
    assign w_accept   = sec_valid & sec_ready;
    // Writes to register 0 are consumed but never stored.
    assign w_push     = w_accept & (sec_waddr != '0);
    // A same-edge pipe write to the same register supersedes the queued result.
    assign w_push_vld = ~(w_pipe_eff & (sec_waddr == pipe_waddr));
    // Valid head pops when the port is free; a squashed head always discards.
    assign w_pop      = ~w_empty & (~w_head_vld | ~w_pipe_eff);

    wb_queue #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_queue (
        .clk           (clk),
        .rst           (rst),
        .i_push        (w_push),
        .i_push_vld    (w_push_vld),
        .i_push_addr   (sec_waddr),
        .i_push_data   (sec_wdata),
        .i_pop         (w_pop),
        .i_sq_en       (w_pipe_eff),
        .i_sq_addr     (pipe_waddr),
        .i_match_addr1 (raddr1),
        .i_match_addr2 (raddr2),
        .o_head_vld    (w_head_vld),
        .o_head_addr   (w_head_addr),
        .o_head_data   (w_head_data),
        .o_empty       (w_empty),
        .o_full        (w_full),
        .o_count       (w_count),
        .o_match1      (w_match1),
        .o_match2      (w_match2)
    );

    // Write-port mux: pipeline first, then a valid queue head, else idle.
    always_comb begin
        rf_we    = WriteDisable;
        rf_waddr = '0;
        rf_wdata = DATA_W'(ZeroWord);
        if (w_pipe_eff) begin
            rf_we    = WriteEnable;
            rf_waddr = pipe_waddr;
            rf_wdata = pipe_wdata;
        end else if (w_head_vld) begin
            rf_we    = WriteEnable;
            rf_waddr = w_head_addr;
            rf_wdata = w_head_data;
        end
    end

    assign pend_hit1 = (re1 == ReadEnable) & (raddr1 != '0) & w_match1;
    assign pend_hit2 = (re2 == ReadEnable) & (raddr2 != '0) & w_match2;
    assign q_count   = w_count;

`ifdef WB_STARVE_STALL_EN
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    logic [WAIT_W-1:0] r_wait;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic              r_stall;

    // Saturating count of cycles the valid head has been held off the port.
    always_comb begin
        w_wait_nxt = r_wait;
        if (w_empty || w_pop) begin
            w_wait_nxt = '0;
        end else if (w_head_vld && (r_wait != WAIT_W'(STARVE_LIMIT))) begin
            w_wait_nxt = r_wait + 1'b1;
        end
    end

    // Stall request registered from the updated wait count; drops after a pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            r_wait  <= '0;
            r_stall <= 1'b0;
        end else begin
            r_wait  <= w_wait_nxt;
            r_stall <= (w_wait_nxt == WAIT_W'(STARVE_LIMIT));
        end
    end

    assign stall_req = r_stall;
`else
    assign stall_req = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_write_arbiter
//  Description : Self-checking bench for wb_write_arbiter: directed scenarios
//                plus randomized traffic against a queue-based reference
//                model. Follows WB_STARVE_STALL_EN for stall expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_write_arbiter;

    localparam int DEPTH = 4;
`ifdef WB_STARVE_STALL_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        sec_valid;
    logic        sec_ready;
    logic [4:0]  sec_waddr;
    logic [31:0] sec_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  raddr1;
    logic        re1;
    logic        pend_hit1;
    logic [4:0]  raddr2;
    logic        re2;
    logic        pend_hit2;
    logic [2:0]  q_count;
    logic        stall_req;

    wb_write_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_we    (pipe_we),
        .pipe_waddr (pipe_waddr),
        .pipe_wdata (pipe_wdata),
        .sec_valid  (sec_valid),
        .sec_ready  (sec_ready),
        .sec_waddr  (sec_waddr),
        .sec_wdata  (sec_wdata),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .raddr1     (raddr1),
        .re1        (re1),
        .pend_hit1  (pend_hit1),
        .raddr2     (raddr2),
        .re2        (re2),
        .pend_hit2  (pend_hit2),
        .q_count    (q_count),
        .stall_req  (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a plain queue of pending results, oldest first.
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        bit          v;
    } ent_t;

    ent_t mq[$];
    bit   m_run;
    int   m_wait;
    bit   m_stall;

    int n_checks;
    int n_errors;

    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_rdy;
    logic        e_h1;
    logic        e_h2;
    logic [2:0]  e_cnt;
    logic        e_stall;

    function automatic bit m_pending(input logic [4:0] ra);
        foreach (mq[i]) begin
            if (mq[i].v && (mq[i].a == ra)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void m_expect();
        bit pe;
        pe      = m_run && pipe_we && (pipe_waddr != 5'd0);
        e_we    = 1'b0;
        e_waddr = 5'd0;
        e_wdata = 32'd0;
        if (pe) begin
            e_we = 1'b1; e_waddr = pipe_waddr; e_wdata = pipe_wdata;
        end else if (mq.size() > 0 && mq[0].v) begin
            e_we = 1'b1; e_waddr = mq[0].a; e_wdata = mq[0].d;
        end
        e_rdy   = m_run && (mq.size() < DEPTH);
        e_h1    = re1 && (raddr1 != 5'd0) && m_pending(raddr1);
        e_h2    = re2 && (raddr2 != 5'd0) && m_pending(raddr2);
        e_cnt   = 3'(mq.size());
        e_stall = m_stall;
    endfunction

    // Advance the model by one clock edge using the inputs held across it.
    task automatic model_edge();
        bit   pe, rdy, hv, popd;
        ent_t e;
        if (rst) begin
            mq.delete(); m_run = 0; m_wait = 0; m_stall = 0;
            return;
        end
        pe   = m_run && pipe_we && (pipe_waddr != 5'd0);
        rdy  = m_run && (mq.size() < DEPTH);
        hv   = (mq.size() > 0) && mq[0].v;
        popd = (mq.size() > 0) && (!hv || !pe);
        if (popd) mq.delete(0);
        if (STARVE_EN) begin
            if (hv && !popd) m_wait++;
            else m_wait = 0;
            m_stall = (m_wait >= 8);
        end
        foreach (mq[i]) begin
            if (pe && (mq[i].a == pipe_waddr)) mq[i].v = 1'b0;
        end
        if (sec_valid && rdy && (sec_waddr != 5'd0)) begin
            e.a = sec_waddr;
            e.d = sec_wdata;
            e.v = !(pe && (sec_waddr == pipe_waddr));
            mq.push_back(e);
        end
        m_run = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        pipe_we = 0; pipe_waddr = 0; pipe_wdata = 0;
        sec_valid = 0; sec_waddr = 0; sec_wdata = 0;
        raddr1 = 0; re1 = 0; raddr2 = 0; re2 = 0;
    endtask

    task automatic assert_rst();
        rst = 1'b1;
        mq.delete(); m_run = 0; m_wait = 0; m_stall = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        re1 = 1; raddr1 = 5'd5;
        #2;
        n_checks++; if (rf_we !== 1'b0) begin n_errors++; $display("FAIL reset_rf_we: got %0b expected 0", rf_we); end
        n_checks++; if (rf_waddr !== 5'd0) begin n_errors++; $display("FAIL reset_rf_waddr: got %0h expected 0", rf_waddr); end
        n_checks++; if (rf_wdata !== 32'd0) begin n_errors++; $display("FAIL reset_rf_wdata: got %0h expected 0", rf_wdata); end
        n_checks++; if (sec_ready !== 1'b0) begin n_errors++; $display("FAIL reset_sec_ready: got %0b expected 0", sec_ready); end
        n_checks++; if (q_count !== 3'd0) begin n_errors++; $display("FAIL reset_q_count: got %0d expected 0", q_count); end
        n_checks++; if (stall_req !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %0b expected 0", stall_req); end
        n_checks++; if (pend_hit1 !== 1'b0) begin n_errors++; $display("FAIL reset_pend_hit1: got %0b expected 0", pend_hit1); end
        tick();
        rst = 1'b0;
        #1;
        n_checks++; if (sec_ready !== 1'b0) begin n_errors++; $display("FAIL release_sec_ready_early: got %0b expected 0", sec_ready); end
        tick();
        n_checks++; if (sec_ready !== 1'b1) begin n_errors++; $display("FAIL release_sec_ready: got %0b expected 1", sec_ready); end
    endtask

    task automatic test_single_drain();
        idle_inputs();
        sec_valid = 1; sec_waddr = 5'd5; sec_wdata = 32'h1234; re1 = 1; raddr1 = 5'd5;
        #1;
        n_checks++; if (rf_we !== 1'b0) begin n_errors++; $display("FAIL drain_push_cycle_we: got %0b expected 0", rf_we); end
        n_checks++; if (pend_hit1 !== 1'b0) begin n_errors++; $display("FAIL drain_push_cycle_hit: got %0b expected 0", pend_hit1); end
        tick();
        sec_valid = 0;
        #1;
        n_checks++; if (q_count !== 3'd1) begin n_errors++; $display("FAIL drain_q_count1: got %0d expected 1", q_count); end
        n_checks++; if (rf_we !== 1'b1) begin n_errors++; $display("FAIL drain_we: got %0b expected 1", rf_we); end
        n_checks++; if (rf_waddr !== 5'd5) begin n_errors++; $display("FAIL drain_waddr: got %0h expected 5", rf_waddr); end
        n_checks++; if (rf_wdata !== 32'h1234) begin n_errors++; $display("FAIL drain_wdata: got %0h expected 1234", rf_wdata); end
        n_checks++; if (pend_hit1 !== 1'b1) begin n_errors++; $display("FAIL drain_hit: got %0b expected 1", pend_hit1); end
        tick();
        n_checks++; if (q_count !== 3'd0) begin n_errors++; $display("FAIL drain_q_count0: got %0d expected 0", q_count); end
        n_checks++; if (rf_we !== 1'b0) begin n_errors++; $display("FAIL drain_after_we: got %0b expected 0", rf_we); end
    endtask

    task automatic test_pipe_priority();
        idle_inputs();
        sec_valid = 1; sec_waddr = 5'd7; sec_wdata = 32'hAA; re1 = 1; raddr1 = 5'd7;
        tick();
        sec_valid = 0; pipe_we = 1; pipe_waddr = 5'd3; pipe_wdata = 32'h55;
        for (int c = 1; c <= 2; c++) begin
            #1;
            n_checks++; if (rf_waddr !== 5'd3) begin n_errors++; $display("FAIL prio_waddr_c%0d: got %0h expected 3", c, rf_waddr); end
            n_checks++; if (rf_wdata !== 32'h55) begin n_errors++; $display("FAIL prio_wdata_c%0d: got %0h expected 55", c, rf_wdata); end
            n_checks++; if (pend_hit1 !== 1'b1) begin n_errors++; $display("FAIL prio_hit_c%0d: got %0b expected 1", c, pend_hit1); end
            tick();
        end
        pipe_we = 0;
        #1;
        n_checks++; if (rf_waddr !== 5'd7) begin n_errors++; $display("FAIL prio_drain_waddr: got %0h expected 7", rf_waddr); end
        n_checks++; if (rf_wdata !== 32'hAA) begin n_errors++; $display("FAIL prio_drain_wdata: got %0h expected aa", rf_wdata); end
        tick();
        n_checks++; if (pend_hit1 !== 1'b0) begin n_errors++; $display("FAIL prio_hit_clear: got %0b expected 0", pend_hit1); end
        n_checks++; if (q_count !== 3'd0) begin n_errors++; $display("FAIL prio_q_count: got %0d expected 0", q_count); end
    endtask

    task automatic test_squash();
        idle_inputs();
        sec_valid = 1; sec_waddr = 5'd9; sec_wdata = 32'h1; re1 = 1; raddr1 = 5'd9;
        tick();
        sec_valid = 0; pipe_we = 1; pipe_waddr = 5'd9; pipe_wdata = 32'h2;
        #1;
        n_checks++; if (rf_wdata !== 32'h2) begin n_errors++; $display("FAIL squash_pipe_wdata: got %0h expected 2", rf_wdata); end
        tick();
        pipe_we = 0;
        #1;
        n_checks++; if (rf_we !== 1'b0) begin n_errors++; $display("FAIL squash_discard_we: got %0b expected 0", rf_we); end
        n_checks++; if (q_count !== 3'd1) begin n_errors++; $display("FAIL squash_q_count1: got %0d expected 1", q_count); end
        n_checks++; if (pend_hit1 !== 1'b0) begin n_errors++; $display("FAIL squash_hit: got %0b expected 0", pend_hit1); end
        tick();
        n_checks++; if (q_count !== 3'd0) begin n_errors++; $display("FAIL squash_q_count0: got %0d expected 0", q_count); end
        // Same-edge push and pipe write to one register: stored squashed.
        sec_valid = 1; sec_waddr = 5'd9; sec_wdata = 32'h3;
        pipe_we = 1; pipe_waddr = 5'd9; pipe_wdata = 32'h4;
        tick();
        idle_inputs(); re1 = 1; raddr1 = 5'd9;
        #1;
        n_checks++; if (q_count !== 3'd1) begin n_errors++; $display("FAIL same_edge_q_count: got %0d expected 1", q_count); end
        n_checks++; if (rf_we !== 1'b0) begin n_errors++; $display("FAIL same_edge_we: got %0b expected 0", rf_we); end
        n_checks++; if (pend_hit1 !== 1'b0) begin n_errors++; $display("FAIL same_edge_hit: got %0b expected 0", pend_hit1); end
        tick();
    endtask

    task automatic test_full();
        idle_inputs();
        pipe_we = 1; pipe_waddr = 5'd1; pipe_wdata = 32'h11;
        for (int k = 0; k < 4; k++) begin
            sec_valid = 1; sec_waddr = 5'(10 + k); sec_wdata = 32'h100 + k;
            #1;
            n_checks++; if (sec_ready !== 1'b1) begin n_errors++; $display("FAIL full_fill_ready_%0d: got %0b expected 1", k, sec_ready); end
            tick();
        end
        sec_waddr = 5'd14; sec_wdata = 32'h104;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++; if (q_count !== 3'd4) begin n_errors++; $display("FAIL full_q_count: got %0d expected 4", q_count); end
            n_checks++; if (sec_ready !== 1'b0) begin n_errors++; $display("FAIL full_ready: got %0b expected 0", sec_ready); end
            n_checks++; if (rf_waddr !== 5'd1) begin n_errors++; $display("FAIL full_pipe_waddr: got %0h expected 1", rf_waddr); end
            tick();
        end
        pipe_we = 0;
        #1;
        n_checks++; if (rf_waddr !== 5'd10) begin n_errors++; $display("FAIL full_pop_waddr: got %0h expected a", rf_waddr); end
        n_checks++; if (sec_ready !== 1'b0) begin n_errors++; $display("FAIL full_no_passthru: got %0b expected 0", sec_ready); end
        tick();
        n_checks++; if (sec_ready !== 1'b1) begin n_errors++; $display("FAIL full_ready_after_pop: got %0b expected 1", sec_ready); end
        n_checks++; if (q_count !== 3'd3) begin n_errors++; $display("FAIL full_q_count3: got %0d expected 3", q_count); end
        tick();
        sec_valid = 0;
        for (int k = 2; k <= 4; k++) begin
            #1;
            n_checks++; if (rf_waddr !== 5'(10 + k)) begin n_errors++; $display("FAIL full_order_waddr_%0d: got %0h expected %0h", k, rf_waddr, 10 + k); end
            n_checks++; if (rf_wdata !== 32'h100 + k) begin n_errors++; $display("FAIL full_order_wdata_%0d: got %0h expected %0h", k, rf_wdata, 32'h100 + k); end
            tick();
        end
        n_checks++; if (q_count !== 3'd0) begin n_errors++; $display("FAIL full_empty: got %0d expected 0", q_count); end
    endtask

    task automatic test_starve();
        logic exp_s;
        idle_inputs();
        sec_valid = 1; sec_waddr = 5'd20; sec_wdata = 32'hBEEF;
        tick();
        sec_valid = 0; pipe_we = 1; pipe_waddr = 5'd2; pipe_wdata = 32'h22;
        for (int c = 1; c <= 10; c++) begin
            exp_s = STARVE_EN && (c >= 9);
            #1;
            n_checks++; if (stall_req !== exp_s) begin n_errors++; $display("FAIL starve_c%0d: got %0b expected %0b", c, stall_req, exp_s); end
            tick();
        end
        pipe_we = 0;
        #1;
        n_checks++; if (rf_waddr !== 5'd20) begin n_errors++; $display("FAIL starve_pop_waddr: got %0h expected 14", rf_waddr); end
        n_checks++; if (stall_req !== STARVE_EN) begin n_errors++; $display("FAIL starve_pop_stall: got %0b expected %0b", stall_req, STARVE_EN); end
        tick();
        n_checks++; if (stall_req !== 1'b0) begin n_errors++; $display("FAIL starve_release: got %0b expected 0", stall_req); end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        pipe_we = 1; pipe_waddr = 5'd1; pipe_wdata = 32'h11;
        for (int k = 0; k < 3; k++) begin
            sec_valid = 1; sec_waddr = 5'(20 + k); sec_wdata = 32'h200 + k;
            tick();
        end
        sec_valid = 0; pipe_we = 0; re1 = 1; raddr1 = 5'd20;
        #1;
        n_checks++; if (q_count !== 3'd3) begin n_errors++; $display("FAIL rstmid_q_count3: got %0d expected 3", q_count); end
        assert_rst();
        #1;
        n_checks++; if (rf_we !== 1'b0) begin n_errors++; $display("FAIL rstmid_we: got %0b expected 0", rf_we); end
        n_checks++; if (q_count !== 3'd0) begin n_errors++; $display("FAIL rstmid_q_count0: got %0d expected 0", q_count); end
        n_checks++; if (sec_ready !== 1'b0) begin n_errors++; $display("FAIL rstmid_ready: got %0b expected 0", sec_ready); end
        n_checks++; if (pend_hit1 !== 1'b0) begin n_errors++; $display("FAIL rstmid_hit: got %0b expected 0", pend_hit1); end
        tick();
        rst = 1'b0;
        tick();
        n_checks++; if (sec_ready !== 1'b1) begin n_errors++; $display("FAIL rstmid_ready_after: got %0b expected 1", sec_ready); end
        n_checks++; if (rf_we !== 1'b0) begin n_errors++; $display("FAIL rstmid_no_write: got %0b expected 0", rf_we); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 63) == 0) assert_rst();
            else rst = 1'b0;
            pipe_we    = ($urandom_range(0, 1) == 1);
            pipe_waddr = 5'($urandom_range(0, 7));
            pipe_wdata = $urandom;
            sec_valid  = ($urandom_range(0, 9) < 6);
            sec_waddr  = 5'($urandom_range(0, 7));
            sec_wdata  = $urandom;
            re1        = ($urandom_range(0, 9) < 7);
            raddr1     = 5'($urandom_range(0, 7));
            re2        = ($urandom_range(0, 9) < 7);
            raddr2     = 5'($urandom_range(0, 7));
            #1;
            m_expect();
            n_checks++; if (rf_we !== e_we) begin n_errors++; $display("FAIL rnd_rf_we[%0d]: got %0b expected %0b", n, rf_we, e_we); end
            n_checks++; if (rf_waddr !== e_waddr) begin n_errors++; $display("FAIL rnd_rf_waddr[%0d]: got %0h expected %0h", n, rf_waddr, e_waddr); end
            n_checks++; if (rf_wdata !== e_wdata) begin n_errors++; $display("FAIL rnd_rf_wdata[%0d]: got %0h expected %0h", n, rf_wdata, e_wdata); end
            n_checks++; if (sec_ready !== e_rdy) begin n_errors++; $display("FAIL rnd_sec_ready[%0d]: got %0b expected %0b", n, sec_ready, e_rdy); end
            n_checks++; if (pend_hit1 !== e_h1) begin n_errors++; $display("FAIL rnd_pend_hit1[%0d]: got %0b expected %0b", n, pend_hit1, e_h1); end
            n_checks++; if (pend_hit2 !== e_h2) begin n_errors++; $display("FAIL rnd_pend_hit2[%0d]: got %0b expected %0b", n, pend_hit2, e_h2); end
            n_checks++; if (q_count !== e_cnt) begin n_errors++; $display("FAIL rnd_q_count[%0d]: got %0d expected %0d", n, q_count, e_cnt); end
            n_checks++; if (stall_req !== e_stall) begin n_errors++; $display("FAIL rnd_stall_req[%0d]: got %0b expected %0b", n, stall_req, e_stall); end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle_inputs();
        assert_rst();
        test_reset();
        test_single_drain();
        test_pipe_priority();
        test_squash();
        test_full();
        test_starve();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
